// File: rtl/seg_scan_driver.sv
// Eight-digit 7-segment scan driver with a double-buffered frame, per-digit blink
// and a blank override, split onto two 4-digit tube banks.
module seg_scan_driver #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [39:0] load_sym,
    input  logic [7:0]  load_dp,
    input  logic [7:0]  load_blink,
    input  logic        blank,
    output logic        pending,
    output logic        frame_sync,
    output logic [7:0]  seg_en,
    output logic [7:0]  tube1,
    output logic [7:0]  tube2
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);

    logic [DW-1:0] dwell_cnt;
    logic [HW-1:0] blink_cnt;
    logic          phase;
    logic [2:0]    idx;

    logic [39:0]   active_sym;
    logic [7:0]    active_dp;
    logic [7:0]    active_blink;
    logic [39:0]   shadow_sym;
    logic [7:0]    shadow_dp;
    logic [7:0]    shadow_blink;

    logic          dwell_wrap;
    logic          commit;
    logic [4:0]    cur_sym;
    logic [7:0]    pattern;

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'b1111110;
            5'd1:    s = 7'b0110000;
            5'd2:    s = 7'b1101101;
            5'd3:    s = 7'b1111001;
            5'd4:    s = 7'b0110011;
            5'd5:    s = 7'b1011011;
            5'd6:    s = 7'b1011111;
            5'd7:    s = 7'b1110000;
            5'd8:    s = 7'b1111111;
            5'd9:    s = 7'b1111011;
            5'd10:   s = 7'b1110111;
            5'd11:   s = 7'b0011111;
            5'd12:   s = 7'b1001110;
            5'd13:   s = 7'b0111101;
            5'd14:   s = 7'b1001111;
            5'd15:   s = 7'b1000111;
            5'd17:   s = 7'b0000001;
            5'd18:   s = 7'b1100111;
            5'd19:   s = 7'b0001110;
            5'd20:   s = 7'b0000101;
            5'd21:   s = 7'b0010101;
            5'd22:   s = 7'b0011101;
            5'd23:   s = 7'b0111110;
            5'd24:   s = 7'b1011011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign dwell_wrap = (dwell_cnt == DWELL_LAST);
    assign commit     = dwell_wrap && (idx == 3'd7);

    always_comb begin
        cur_sym = 5'd16;
        for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) begin
                cur_sym = active_sym[5*i +: 5];
            end
        end
        if (!phase && active_blink[idx]) begin
            pattern = 8'h00;
        end else begin
            pattern = {decode(cur_sym), active_dp[idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            idx       <= 3'd0;
        end else begin
            dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + 1'b1;
            if (dwell_wrap) begin
                idx <= idx + 3'd1;
            end
            if (blink_cnt == HALF_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // A load landing on the commit edge skips the shadow and goes straight to active.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_sym   <= {8{5'd16}};
            active_dp    <= 8'h00;
            active_blink <= 8'h00;
            shadow_sym   <= {8{5'd16}};
            shadow_dp    <= 8'h00;
            shadow_blink <= 8'h00;
            pending      <= 1'b0;
            frame_sync   <= 1'b0;
        end else begin
            frame_sync <= 1'b0;
            if (commit) begin
                if (load) begin
                    active_sym   <= load_sym;
                    active_dp    <= load_dp;
                    active_blink <= load_blink;
                    pending      <= 1'b0;
                    frame_sync   <= 1'b1;
                end else if (pending) begin
                    active_sym   <= shadow_sym;
                    active_dp    <= shadow_dp;
                    active_blink <= shadow_blink;
                    pending      <= 1'b0;
                    frame_sync   <= 1'b1;
                end
            end else if (load) begin
                shadow_sym   <= load_sym;
                shadow_dp    <= load_dp;
                shadow_blink <= load_blink;
                pending      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || blank) begin
            seg_en <= 8'h00;
            tube1  <= 8'h00;
            tube2  <= 8'h00;
        end else begin
            seg_en <= 8'b1 << idx;
            if (!idx[2]) begin
                tube1 <= pattern;
                tube2 <= 8'h00;
            end else begin
                tube1 <= 8'h00;
                tube2 <= pattern;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DWELL=8, HALF=40, vectors keyed to the
// absolute edge count since reset release, plus a hand-written blank/reset sequence.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [39:0] load_sym;
    logic [7:0]  load_dp;
    logic [7:0]  load_blink;
    logic        blank;
    logic        pending;
    logic        frame_sync;
    logic [7:0]  seg_en;
    logic [7:0]  tube1;
    logic [7:0]  tube2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        int          cyc;
        logic        load;
        logic [39:0] sym;
        logic [7:0]  dp;
        logic [7:0]  blink;
        logic        blank;
        logic [7:0]  seg;
        logic [7:0]  t1;
        logic [7:0]  t2;
        logic        pend;
        logic        fs;
    } vec_t;

    vec_t vecs[$];

    localparam logic [39:0] S2  = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [39:0] S8  = {8{5'd8}};
    localparam logic [39:0] S17 = {8{5'd17}};
    localparam logic [39:0] S4  = {5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24};
    localparam logic [39:0] S5  = {5'd1, 5'd1, 5'd1, 5'd18, 5'd1, 5'd1, 5'd1, 5'd1};

    seg_scan_driver #(.CLK_HZ(80), .SCAN_HZ(10), .BLINK_HZ(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_sym   (load_sym),
        .load_dp    (load_dp),
        .load_blink (load_blink),
        .blank      (blank),
        .pending    (pending),
        .frame_sync (frame_sync),
        .seg_en     (seg_en),
        .tube1      (tube1),
        .tube2      (tube2)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input int c, input logic ld,
                                input logic [39:0] s, input logic [7:0] d,
                                input logic [7:0] b, input logic bl,
                                input logic [7:0] sg, input logic [7:0] t1,
                                input logic [7:0] t2, input logic p, input logic f);
        vec_t v;
        v.nm = nm; v.cyc = c; v.load = ld; v.sym = s; v.dp = d; v.blink = b;
        v.blank = bl; v.seg = sg; v.t1 = t1; v.t2 = t2; v.pend = p; v.fs = f;
        return v;
    endfunction

    // One active edge, then park on the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input string nm, input logic [7:0] sg, input logic [7:0] t1,
                               input logic [7:0] t2, input logic p, input logic f);
        cmp({nm, ".seg_en"}, seg_en, sg);
        cmp({nm, ".tube1"}, tube1, t1);
        cmp({nm, ".tube2"}, tube2, t2);
        cmp({nm, ".pending"}, {7'd0, pending}, {7'd0, p});
        cmp({nm, ".frame_sync"}, {7'd0, frame_sync}, {7'd0, f});
    endtask

    task automatic applyStimulus(input vec_t v);
        while (cyc < v.cyc - 1) tick();
        load       = v.load;
        load_sym   = v.sym;
        load_dp    = v.dp;
        load_blink = v.blink;
        blank      = v.blank;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_sym = '0; load_dp = '0; load_blink = '0; blank = 1'b0;

        // free run, no load
        vecs.push_back(mk("t1_c1",   1,  0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c8",   8,  0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c9",   9,  0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c17",  17, 0, 0, 0, 0, 0, 8'h04, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c25",  25, 0, 0, 0, 0, 0, 8'h08, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c33",  33, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c41",  41, 0, 0, 0, 0, 0, 8'h20, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c49",  49, 0, 0, 0, 0, 0, 8'h40, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c57",  57, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c64",  64, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t1_c65",  65, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0));
        // mid-frame load of 0..7, dp on digit 0
        vecs.push_back(mk("t2_load", 90,  1, S2, 8'h01, 0, 0, 8'h08, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk("t2_c127", 127, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk("t2_c128", 128, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk("t2_c129", 129, 0, 0, 0, 0, 0, 8'h01, 8'hFD, 8'h00, 0, 0));
        vecs.push_back(mk("t2_c136", 136, 0, 0, 0, 0, 0, 8'h01, 8'hFD, 8'h00, 0, 0));
        vecs.push_back(mk("t2_c137", 137, 0, 0, 0, 0, 0, 8'h02, 8'h60, 8'h00, 0, 0));
        // two loads in one frame
        vecs.push_back(mk("t3_ld8",  140, 1, S8,  0, 0, 0, 8'h02, 8'h60, 8'h00, 1, 0));
        vecs.push_back(mk("t3_ld17", 150, 1, S17, 0, 0, 0, 8'h04, 8'hDA, 8'h00, 1, 0));
        vecs.push_back(mk("t2_c161", 161, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h66, 1, 0));
        vecs.push_back(mk("t2_c185", 185, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'hE0, 1, 0));
        vecs.push_back(mk("t3_c191", 191, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'hE0, 1, 0));
        vecs.push_back(mk("t3_c192", 192, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'hE0, 0, 1));
        vecs.push_back(mk("t3_c193", 193, 0, 0, 0, 0, 0, 8'h01, 8'h02, 8'h00, 0, 0));
        vecs.push_back(mk("t3_c225", 225, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h02, 0, 0));
        // load exactly on the commit edge
        vecs.push_back(mk("t4_c255", 255, 0, 0,  0, 0, 0, 8'h80, 8'h00, 8'h02, 0, 0));
        vecs.push_back(mk("t4_ld",   256, 1, S4, 0, 0, 0, 8'h80, 8'h00, 8'h02, 0, 1));
        vecs.push_back(mk("t4_c257", 257, 0, 0, 0, 0, 0, 8'h01, 8'hB6, 8'h00, 0, 0));
        vecs.push_back(mk("t4_c265", 265, 0, 0, 0, 0, 0, 8'h02, 8'h7C, 8'h00, 0, 0));
        vecs.push_back(mk("t4_c273", 273, 0, 0, 0, 0, 0, 8'h04, 8'h3A, 8'h00, 0, 0));
        vecs.push_back(mk("t4_c281", 281, 0, 0, 0, 0, 0, 8'h08, 8'h2A, 8'h00, 0, 0));
        vecs.push_back(mk("t4_c289", 289, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h0A, 0, 0));
        vecs.push_back(mk("t4_c297", 297, 0, 0, 0, 0, 0, 8'h20, 8'h00, 8'h1C, 0, 0));
        vecs.push_back(mk("t4_c305", 305, 0, 0, 0, 0, 0, 8'h40, 8'h00, 8'hCE, 0, 0));
        vecs.push_back(mk("t4_c313", 313, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'h02, 0, 0));
        // blink on digit 4 showing 'P'
        vecs.push_back(mk("t5_ld",   330, 1, S5, 0, 8'h10, 0, 8'h02, 8'h7C, 8'h00, 1, 0));
        vecs.push_back(mk("t5_c384", 384, 0, 0, 0, 0, 0, 8'h80, 8'h00, 8'h02, 0, 1));
        vecs.push_back(mk("t5_c417", 417, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'hCE, 0, 0));
        vecs.push_back(mk("t5_c424", 424, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'hCE, 0, 0));
        vecs.push_back(mk("t5_c537", 537, 0, 0, 0, 0, 0, 8'h08, 8'h60, 8'h00, 0, 0));
        vecs.push_back(mk("t5_c545", 545, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t5_c552", 552, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t5_c553", 553, 0, 0, 0, 0, 0, 8'h20, 8'h00, 8'h60, 0, 0));
        vecs.push_back(mk("t5_c609", 609, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("t5_c673", 673, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'hCE, 0, 0));

        $display("[TB] reset and vector table (%0d entries)", vecs.size());
        repeat (3) tick();
        checkOutput("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        cyc = 0;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkOutput(vecs[k].nm, vecs[k].seg, vecs[k].t1, vecs[k].t2, vecs[k].pend, vecs[k].fs);
        end

        // blank window, then reset mid-frame with a frame pending
        $display("[TB] blank and mid-frame reset sequence");
        while (cyc < 700) tick();
        blank = 1'b1;
        tick();
        checkOutput("t6_blank_c701", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        while (cyc < 720) tick();
        checkOutput("t6_blank_c720", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        blank = 1'b0;
        tick();
        checkOutput("t6_unblank_c721", 8'h04, 8'h60, 8'h00, 1'b0, 1'b0);
        load = 1'b1; load_sym = S2; load_dp = 8'h01; load_blink = 8'h00;
        tick();
        load = 1'b0;
        checkOutput("t6_pend_c722", 8'h04, 8'h60, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        cyc = 0;
        tick();
        checkOutput("t6_r1", 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        while (cyc < 9) tick();
        checkOutput("t6_r9", 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
        while (cyc < 64) tick();
        checkOutput("t6_r64", 8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("t6_r65", 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage of the top-level mode controller.
- Takes an 8-digit symbol frame plus decimal-point and blink masks. Decodes each symbol to 7-segment patterns and time-multiplexes them onto the board's two 4-digit tube banks.
- Double-buffered so the controller can post a new frame at any cycle without tearing.
- Replaces direct driving of tube1/tube2/seg_en from mode logic.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- SCAN_HZ, 1000, digit-advance rate. DWELL = CLK_HZ/SCAN_HZ cycles per digit; DWELL must be >= 2.
- BLINK_HZ, 2, blink rate. Blink phase toggles every HALF = CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe: capture frame inputs
- load_sym  in  40  8 x 5-bit symbol codes; digit i = bits [5i+4:5i]; digit 0 leftmost
- load_dp  in  8  decimal point per digit, 1 = lit
- load_blink  in  8  blink enable per digit
- blank  in  1  level: display off while high
- pending  out  1  shadow frame awaiting commit
- frame_sync  out  1  one-cycle pulse on each commit
- seg_en  out  8  one-hot digit enable, active-high, bit i = digit i
- tube1  out  8  segments for digits 0-3, {a,b,c,d,e,f,g,dp}, active-high
- tube2  out  8  segments for digits 4-7, same encoding

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset values (on any clk edge with rst=1, including mid-frame or mid-blink):
  - seg_en=0, tube1=0, tube2=0, pending=0, frame_sync=0.
  - Digit index=0, dwell counter=0, blink counter=0, blink phase=1 (visible).
  - Active and shadow symbols all 16 (blank); dp and blink masks all 0.
- Symbol decode (5-bit code):
  - 0-15: hex digits 0-F (b and d lowercase).
  - 16: blank.
  - 17: '-' (g only).
  - 18: 'P'. 19: 'L'. 20: 'r'. 21: 'n'. 22: 'o'. 23: 'U'. 24: 'S'.
  - 25-31: blank.
  - dp bit = dp mask bit.
- Scan:
  - Dwell counter counts 0..DWELL-1 and wraps.
  - On wrap, digit index increments mod 8; 7 -> 0 is the frame boundary.
- Outputs are registered and reflect the current digit index one cycle after the index changes.
  - seg_en = 1<<idx.
  - If idx<4: tube1 = decode(active[idx]), tube2 = 0. Otherwise tube2 = decode, tube1 = 0.
- Blink:
  - Blink counter counts 0..HALF-1 and wraps; the phase toggles on each wrap.
  - When phase=0 and blink[idx]=1, the tube pattern is 0 while seg_en stays asserted.
- blank=1: seg_en=0 and tubes=0 from the next edge. Scan, blink and commit counters keep running.
- Load / commit:
  - load=1 writes shadow (sym, dp, blink) and sets pending.
  - A later load before commit overwrites the shadow; the last one wins.
  - Commit happens on the edge where dwell wraps with idx=7:
    - If pending: active <= shadow, pending <= 0, frame_sync pulses the following cycle.
    - If not pending: no frame_sync pulse.
  - load on the commit edge: load data is committed directly to active (bypass), pending=0, frame_sync pulses.
  - New data first appears on digit 0 of the new frame. Worst-case latency is 8*DWELL+1 cycles from load to first visible digit.
- Width rules:
  - Counters are sized to $clog2 of their terminal count.
  - No arithmetic overflow paths; the index is 3 bits with natural wrap.

Test Plan:
Common setup: CLK_HZ=80, SCAN_HZ=10 (DWELL=8), BLINK_HZ=1 (HALF=40).
1. Reset then free-run, no load.
   - seg_en cycles 0x01,0x02,...,0x80 with 8 cycles each.
   - tube1 = tube2 = 0 throughout (all blank).
2. load with symbols {0,1,2,3,4,5,6,7}, dp=0x01, at mid-frame (idx=3).
   - pending=1 until the idx 7->0 edge, then frame_sync pulses once.
   - Digit 0 shows tube1=0xFD (0 + dp). Digit 4 shows tube2=0x66 ('4').
3. Two loads in the same frame (all 8s, then all 17s).
   - Only the '-' frame appears: tube = 0x02.
   - Exactly one frame_sync pulse.
4. load asserted exactly on the commit edge.
   - Data visible on digit 0 in the next frame.
   - pending never observed 1; frame_sync pulses.
5. blink=0x10 with symbol 'P' (18) on digit 4.
   - tube2 alternates 0xCE / 0x00 every 40 cycles while seg_en=0x10.
   - Other digits are unaffected.
6. blank=1 for 20 cycles, then rst=1 asserted mid-frame.
   - While blank: seg_en=0 and tubes=0.
   - After rst: all outputs 0, pending cleared, and scanning restarts at digit 0 once rst deasserts.
